// File: rtl/pcm_agc.sv
// pcm_agc: peak-driven automatic gain control for the vocal PCM path.
// Three register stages: multiply, shift/saturate, output + gain update.
//
// state   | meaning
// --------+--------------------------------------------------------------
// RELEASE | hold expired; gain creeps up per sample unless gated by noise
// ATTACK  | last output was too hot; gain was just reduced
// HOLD    | counting down valid samples before release may start
module pcm_agc #(
    parameter int TARGET       = 16384,
    parameter int NOISE_FLOOR  = 256,
    parameter int HOLD_SAMPLES = 1600,
    parameter int ATTACK_SHIFT = 4,
    parameter int RELEASE_STEP = 1,
    parameter int GAIN_MIN     = 64,
    parameter int GAIN_MAX     = 2048
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] x_in,
    input  logic        x_in_valid,
    input  logic        bypass,
    input  logic        clip_clear,
    output logic [15:0] y_out,
    output logic        y_out_valid,
    output logic [11:0] gain,
    output logic        clipped,
    output logic [1:0]  agc_state
);

    typedef enum logic [1:0] {
        ST_RELEASE = 2'd0,
        ST_ATTACK  = 2'd1,
        ST_HOLD    = 2'd2
    } agc_state_t;

    localparam logic [16:0] TARGET_W   = 17'(TARGET);
    localparam logic [16:0] NOISE_W    = 17'(NOISE_FLOOR);
    // Reload value is clamped to what the 11-bit counter can hold.
    localparam logic [10:0] HOLD_W     = (HOLD_SAMPLES > 2047) ? 11'd2047 : 11'(HOLD_SAMPLES);
    localparam logic [12:0] GMIN_W     = 13'(GAIN_MIN);
    localparam logic [12:0] GMAX_W     = 13'(GAIN_MAX);
    localparam logic [12:0] RSTEP_W    = 13'(RELEASE_STEP);
    localparam logic [11:0] GAIN_UNITY = 12'd256;

    agc_state_t        state_r, state_nx;
    logic [11:0]       gain_r, gain_nx;
    logic [10:0]       cnt_r, cnt_nx;

    logic [16:0]       x_abs;
    logic signed [28:0] prod;

    logic signed [28:0] p_s1;
    logic               nf_s1;
    logic               v_s1;

    logic signed [20:0] q;
    logic               sat_c;
    logic [15:0]        y_c;

    logic [15:0]        y_s2;
    logic               sat_s2;
    logic               nf_s2;
    logic               v_s2;

    logic [16:0]        y_abs;
    logic               hot;
    logic [12:0]        gain_ext;
    logic [12:0]        atk_step;
    logic [12:0]        gain_atk;
    logic [12:0]        gain_rel;

    // Stage-1 arithmetic: magnitude for the noise gate and the Q4.8 product.
    always_comb begin
        x_abs = x_in[15] ? (17'd0 - {1'b1, x_in}) : {1'b0, x_in};
        prod  = 29'($signed(x_in)) * 29'($signed({1'b0, gain_r}));
    end

    // Stage 1: capture product and noise flag on each valid input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_s1  <= '0;
            nf_s1 <= 1'b0;
            v_s1  <= 1'b0;
        end else begin
            v_s1 <= x_in_valid;
            if (x_in_valid) begin
                p_s1  <= prod;
                nf_s1 <= (x_abs < NOISE_W);
            end
        end
    end

    // Drop the 8 fractional bits (floor) and clamp to 16-bit range.
    always_comb begin
        q     = p_s1[28:8];
        sat_c = (q > 21'sd32767) || (q < -21'sd32768);
        if (sat_c) begin
            y_c = q[20] ? 16'h8000 : 16'h7fff;
        end else begin
            y_c = q[15:0];
        end
    end

    // Stage 1b: register the saturated sample and its side flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_s2   <= '0;
            sat_s2 <= 1'b0;
            nf_s2  <= 1'b0;
            v_s2   <= 1'b0;
        end else begin
            v_s2 <= v_s1;
            if (v_s1) begin
                y_s2   <= y_c;
                sat_s2 <= sat_c;
                nf_s2  <= nf_s1;
            end
        end
    end

    // Candidate gains for attack (proportional step, at least 1) and release.
    always_comb begin
        y_abs    = y_s2[15] ? (17'd0 - {1'b1, y_s2}) : {1'b0, y_s2};
        hot      = sat_s2 || (y_abs > TARGET_W);
        gain_ext = {1'b0, gain_r};
        atk_step = {1'b0, gain_r >> ATTACK_SHIFT};
        if (atk_step == 13'd0) begin
            atk_step = 13'd1;
        end
        if (gain_ext >= GMIN_W + atk_step) begin
            gain_atk = gain_ext - atk_step;
        end else begin
            gain_atk = GMIN_W;
        end
        gain_rel = gain_ext + RSTEP_W;
        if (gain_rel > GMAX_W) begin
            gain_rel = GMAX_W;
        end
    end

    // Next-state and gain decision, evaluated only when a sample leaves stage 1b.
    always_comb begin
        state_nx = state_r;
        gain_nx  = gain_r;
        cnt_nx   = cnt_r;
        if (v_s2) begin
            if (bypass) begin
                state_nx = ST_HOLD;
                gain_nx  = GAIN_UNITY;
                cnt_nx   = HOLD_W;
            end else if (hot) begin
                state_nx = ST_ATTACK;
                gain_nx  = gain_atk[11:0];
                cnt_nx   = HOLD_W;
            end else if (cnt_r != 11'd0) begin
                state_nx = ST_HOLD;
                cnt_nx   = cnt_r - 11'd1;
            end else if (nf_s2) begin
                state_nx = ST_RELEASE;
            end else begin
                state_nx = ST_RELEASE;
                gain_nx  = gain_rel[11:0];
            end
        end
    end

    // AGC state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_HOLD;
            gain_r  <= GAIN_UNITY;
            cnt_r   <= HOLD_W;
        end else begin
            state_r <= state_nx;
            gain_r  <= gain_nx;
            cnt_r   <= cnt_nx;
        end
    end

    // Output register and sticky clip flag; a new clip wins over a clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_out       <= '0;
            y_out_valid <= 1'b0;
            clipped     <= 1'b0;
        end else begin
            y_out_valid <= v_s2;
            if (v_s2) begin
                y_out <= y_s2;
            end
            if (v_s2 && sat_s2) begin
                clipped <= 1'b1;
            end else if (clip_clear) begin
                clipped <= 1'b0;
            end
        end
    end

    assign gain      = gain_r;
    assign agc_state = state_r;

endmodule
